// File: rtl/sub_vram_arbiter.sv
// Arbitrates the three sub-CPU VRAM planes between display fetch (priority) and sub-CPU accesses.
// Optional one-entry posted write buffer is enabled with `define SUB_VRAM_WBUF_EN.
module sub_vram_arbiter #(
  parameter int AW         = 14,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_plane,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ready,
  input  logic [2:0]    vpage_mask,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [23:0]   disp_data,
  output logic          disp_ack,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_ce,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [23:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  localparam logic [1:0] OWN_CPU = 2'd0, OWN_DISP = 2'd1, OWN_DRAIN = 2'd2;

  function automatic logic [2:0] plane_onehot(input logic [1:0] p);
    case (p)
      2'd0:    plane_onehot = 3'b001;
      2'd1:    plane_onehot = 3'b010;
      2'd2:    plane_onehot = 3'b100;
      default: plane_onehot = 3'b000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d, own_q, own_d, plane_q, plane_d;
  logic            rd_q, rd_d, byp_q, byp_d;
  logic [3:0]      starve_q, starve_d;
  logic            cpu_ready_q, cpu_ready_d, disp_ack_q, disp_ack_d, mem_we_q, mem_we_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d, mem_wdata_q, mem_wdata_d;
  logic [23:0]     disp_data_q, disp_data_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [2:0]      mem_ce_q, mem_ce_d;
  logic            cpu_vis_s, plane_on_s, wb_take_s, cpu_cand_s, drain_cand_s, pend_s, forced_s;
  logic            gnt_disp_s, gnt_cpu_s, gnt_drain_s;
  logic            wb_vld_q;
  logic [AW-1:0]   wb_addr_q;
  logic [7:0]      wb_data_q;
  logic [1:0]      wb_plane_q;

  // Arbitration: candidate requesters, grant decision and starvation counter update.
  always_comb begin
    // While cpu_ready is high the requester is still holding the request it is retiring.
    cpu_vis_s = cpu_req & ~cpu_ready_q;
    case (cpu_plane)
      2'd0:    plane_on_s = ~vpage_mask[0];
      2'd1:    plane_on_s = ~vpage_mask[1];
      2'd2:    plane_on_s = ~vpage_mask[2];
      default: plane_on_s = 1'b0;
    endcase
`ifdef SUB_VRAM_WBUF_EN
    wb_take_s    = (state_q == S_IDLE) & cpu_vis_s & cpu_we & plane_on_s & ~wb_vld_q;
    cpu_cand_s   = cpu_vis_s & ~wb_take_s & ~wb_vld_q;
    drain_cand_s = wb_vld_q;
`else
    wb_take_s    = 1'b0;
    cpu_cand_s   = cpu_vis_s;
    drain_cand_s = 1'b0;
`endif
    pend_s      = cpu_cand_s | drain_cand_s;
    forced_s    = (starve_q == 4'(STARVE_MAX));
    gnt_disp_s  = (state_q == S_IDLE) & disp_req & ~(forced_s & pend_s);
    gnt_drain_s = (state_q == S_IDLE) & ~gnt_disp_s & drain_cand_s;
    gnt_cpu_s   = (state_q == S_IDLE) & ~gnt_disp_s & ~drain_cand_s & cpu_cand_s;
    starve_d    = starve_q;
    if (state_q == S_IDLE) begin
      if (gnt_disp_s && pend_s) begin
        starve_d = forced_s ? starve_q : starve_q + 4'd1;
      end else if (gnt_cpu_s || gnt_drain_s || !pend_s) begin
        starve_d = 4'd0;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE:  state_d = (gnt_disp_s | gnt_cpu_s | gnt_drain_s) ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        wcnt_d  = 2'd0;
        state_d = (rd_q & ~byp_q) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (wcnt_q == 2'(MEM_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and access-context logic; all values land in registers.
  always_comb begin
    own_d       = own_q;
    rd_d        = rd_q;
    byp_d       = byp_q;
    plane_d     = plane_q;
    cpu_ready_d = 1'b0;
    disp_ack_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    disp_data_d = disp_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ce_d    = 3'b000;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_ready_d = wb_take_s;
        if (gnt_disp_s) begin
          own_d = OWN_DISP; rd_d = 1'b1; byp_d = 1'b0; plane_d = 2'd0;
          mem_addr_d = disp_addr; mem_ce_d = 3'b111;
        end else if (gnt_drain_s) begin
          own_d = OWN_DRAIN; rd_d = 1'b0; byp_d = 1'b0; plane_d = wb_plane_q;
          mem_addr_d = wb_addr_q; mem_wdata_d = wb_data_q;
          mem_ce_d = plane_onehot(wb_plane_q); mem_we_d = 1'b1;
        end else if (gnt_cpu_s) begin
          own_d = OWN_CPU; rd_d = ~cpu_we; byp_d = ~plane_on_s; plane_d = cpu_plane;
          mem_addr_d = cpu_addr; mem_wdata_d = cpu_wdata;
          mem_ce_d = plane_on_s ? plane_onehot(cpu_plane) : 3'b000;
          mem_we_d = cpu_we & plane_on_s;
        end else begin
          own_d = own_q;
        end
      end
      S_ISSUE: begin
        // Writes and masked accesses finish without a RAM wait.
        if (!(rd_q && !byp_q) && own_q == OWN_CPU) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = rd_q ? 8'hFF : cpu_rdata_q;
        end else begin
          cpu_ready_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 2'(MEM_LAT - 1)) begin
          if (own_q == OWN_DISP) begin
            disp_ack_d  = 1'b1;
            disp_data_d = mem_rdata;
          end else begin
            cpu_ready_d = 1'b1;
            case (plane_q)
              2'd0:    cpu_rdata_d = mem_rdata[7:0];
              2'd1:    cpu_rdata_d = mem_rdata[15:8];
              2'd2:    cpu_rdata_d = mem_rdata[23:16];
              default: cpu_rdata_d = 8'hFF;
            endcase
          end
        end else begin
          disp_ack_d = 1'b0;
        end
      end
      S_DONE:  cpu_ready_d = 1'b0;
      default: cpu_ready_d = 1'b0;
    endcase
  end

  // FSM state and access-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 2'd0;
      own_q    <= OWN_CPU;
      rd_q     <= 1'b0;
      byp_q    <= 1'b0;
      plane_q  <= 2'd0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      own_q    <= own_d;
      rd_q     <= rd_d;
      byp_q    <= byp_d;
      plane_q  <= plane_d;
      starve_q <= starve_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ready_q <= 1'b0;
      disp_ack_q  <= 1'b0;
      cpu_rdata_q <= 8'h00;
      disp_data_q <= 24'h000000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_ce_q    <= 3'b000;
      mem_we_q    <= 1'b0;
    end else begin
      cpu_ready_q <= cpu_ready_d;
      disp_ack_q  <= disp_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      disp_data_q <= disp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
    end
  end

`ifdef SUB_VRAM_WBUF_EN
  // Posted write buffer: filled on an accepted CPU write, emptied when its drain is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= 8'h00;
      wb_plane_q <= 2'd0;
    end else if (wb_take_s) begin
      wb_vld_q   <= 1'b1;
      wb_addr_q  <= cpu_addr;
      wb_data_q  <= cpu_wdata;
      wb_plane_q <= cpu_plane;
    end else if (gnt_drain_s) begin
      wb_vld_q   <= 1'b0;
    end
  end
`else
  assign wb_vld_q   = 1'b0;
  assign wb_addr_q  = '0;
  assign wb_data_q  = 8'h00;
  assign wb_plane_q = 2'd0;
`endif

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign disp_ack  = disp_ack_q;
  assign disp_data = disp_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sub_vram_arbiter.sv
// Directed, table-driven bench for sub_vram_arbiter with a one-cycle-latency plane RAM model.
module tb_sub_vram_arbiter;
  localparam int AW = 14;
`ifdef SUB_VRAM_WBUF_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam int WR_RDY = WB ? 1 : 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, disp_req = 1'b0;
  logic [1:0]    cpu_plane = 2'd0;
  logic [AW-1:0] cpu_addr = '0, disp_addr = '0;
  logic [7:0]    cpu_wdata = 8'h00, cpu_rdata, mem_wdata;
  logic          cpu_ready, disp_ack, mem_we;
  logic [2:0]    vpage_mask = 3'b000, mem_ce;
  logic [23:0]   disp_data, mem_rdata = 24'h0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    ram_b [0:(1<<AW)-1];
  logic [7:0]    ram_r [0:(1<<AW)-1];
  logic [7:0]    ram_g [0:(1<<AW)-1];
  int            n_checks = 0, n_errors = 0;

  sub_vram_arbiter #(.AW(AW), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_plane(cpu_plane), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vpage_mask(vpage_mask), .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_ack(disp_ack), .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Plane RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_ce[0] && mem_we) ram_b[mem_addr] <= mem_wdata;
    if (mem_ce[1] && mem_we) ram_r[mem_addr] <= mem_wdata;
    if (mem_ce[2] && mem_we) ram_g[mem_addr] <= mem_wdata;
    if (|mem_ce) mem_rdata <= {ram_g[mem_addr], ram_r[mem_addr], ram_b[mem_addr]};
  end

  typedef struct {
    logic [1:0]  plane;
    logic [13:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [2:0]  mask;
    logic [2:0]  exp_ce;
    int          exp_rdy;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [2:0] wce(input logic [2:0] ce);
    return WB ? 3'b000 : ce;
  endfunction

  // One CPU transaction; cycle 0 is the cycle the request is first presented.
  task automatic run_cpu(input logic [1:0] pl, input logic [13:0] ad, input logic we,
                         input logic [7:0] wd, output logic [2:0] ce_or, output int ce_cnt,
                         output int rdy, output logic [7:0] rd);
    cpu_plane = pl; cpu_addr = ad; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
    ce_or = 3'b000; ce_cnt = 0; rdy = -1; rd = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_ce != 3'b000) begin
        ce_or = ce_or | mem_ce;
        ce_cnt++;
      end
      if (cpu_ready) begin
        rdy = c; rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic run_disp(input logic [13:0] ad, output logic [2:0] ce_or, output int ack,
                          output logic [23:0] dd);
    disp_addr = ad; disp_req = 1'b1; ce_or = 3'b000; ack = -1; dd = 24'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      ce_or = ce_or | mem_ce;
      if (disp_ack) begin
        ack = c; dd = disp_data;
        break;
      end
    end
    disp_req = 1'b0;
  endtask

  initial begin
    logic [2:0]  ce_or;
    logic [7:0]  rd;
    logic [23:0] dd;
    int          ce_cnt, rdy, ack, acks_before, acks_after, pulses;
    logic        cpu_done;

    vecs[0]  = '{2'd0, 14'h0123, 1'b1, 8'h5A, 3'b000, wce(3'b001), WR_RDY, 8'h00};
    vecs[1]  = '{2'd0, 14'h0123, 1'b0, 8'h00, 3'b000, 3'b001, 3, 8'h5A};
    vecs[2]  = '{2'd1, 14'h0123, 1'b1, 8'hA5, 3'b000, wce(3'b010), WR_RDY, 8'h00};
    vecs[3]  = '{2'd1, 14'h0123, 1'b0, 8'h00, 3'b000, 3'b010, 3, 8'hA5};
    vecs[4]  = '{2'd2, 14'h3FFF, 1'b1, 8'hC3, 3'b000, wce(3'b100), WR_RDY, 8'h00};
    vecs[5]  = '{2'd2, 14'h3FFF, 1'b0, 8'h00, 3'b000, 3'b100, 3, 8'hC3};
    vecs[6]  = '{2'd2, 14'h0123, 1'b1, 8'h3C, 3'b000, wce(3'b100), WR_RDY, 8'h00};
    vecs[7]  = '{2'd2, 14'h0123, 1'b0, 8'h00, 3'b000, 3'b100, 3, 8'h3C};
    vecs[8]  = '{2'd1, 14'h0010, 1'b0, 8'h00, 3'b010, 3'b000, 2, 8'hFF};
    vecs[9]  = '{2'd1, 14'h0123, 1'b1, 8'h11, 3'b010, 3'b000, 2, 8'h00};
    vecs[10] = '{2'd1, 14'h0123, 1'b0, 8'h00, 3'b000, 3'b010, 3, 8'hA5};
    vecs[11] = '{2'd3, 14'h0000, 1'b0, 8'h00, 3'b000, 3'b000, 2, 8'hFF};
    vecs[12] = '{2'd2, 14'h3FFF, 1'b0, 8'h00, 3'b001, 3'b100, 3, 8'hC3};

    // Reset state.
    #2;
    chk("reset_outputs", {8'h0, cpu_rdata, 7'h0, cpu_ready, disp_ack, mem_ce, mem_we},
        32'h0);
    chk("reset_data", {disp_data, mem_wdata}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      vpage_mask = vecs[i].mask;
      run_cpu(vecs[i].plane, vecs[i].addr, vecs[i].we, vecs[i].wdata, ce_or, ce_cnt, rdy, rd);
      chk($sformatf("vec%0d_ce", i), {29'h0, ce_or}, {29'h0, vecs[i].exp_ce});
      chk($sformatf("vec%0d_ready_cycle", i), rdy, vecs[i].exp_rdy);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), {24'h0, rd}, {24'h0, vecs[i].exp_rdata});
      idle(6);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata_hold", i), {24'h0, cpu_rdata},
                           {24'h0, vecs[i].exp_rdata});
    end
    vpage_mask = 3'b000;

    // Display fetch across all planes.
    run_disp(14'h0123, ce_or, ack, dd);
    chk("disp_ce", {29'h0, ce_or}, 32'h7);
    chk("disp_ack_cycle", ack, 3);
    chk("disp_data", {8'h0, dd}, 32'h003CA55A);
    idle(4);

    // Simultaneous requests with cleared starvation: display first, CPU right after.
    disp_addr = 14'h3FFF; disp_req = 1'b1;
    cpu_plane = 2'd0; cpu_addr = 14'h0123; cpu_we = 1'b0; cpu_req = 1'b1;
    ack = -1; rdy = -1;
    for (int c = 1; c <= 20 && rdy < 0; c++) begin
      @(posedge clk); #1;
      if (disp_ack) begin ack = c; disp_req = 1'b0; end
      if (cpu_ready) begin rdy = c; rd = cpu_rdata; cpu_req = 1'b0; end
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    chk("simul_disp_ack_cycle", ack, 3);
    chk("simul_cpu_ready_cycle", rdy, 7);
    chk("simul_cpu_rdata", {24'h0, rd}, 32'h5A);
    idle(4);

    // Starvation bound: continuous display with a pending CPU read.
    disp_addr = 14'h0123; disp_req = 1'b1;
    cpu_plane = 2'd0; cpu_addr = 14'h0123; cpu_we = 1'b0; cpu_req = 1'b1;
    acks_before = 0; acks_after = 0; cpu_done = 1'b0; rd = 8'h00; dd = 24'h0;
    for (int c = 1; c <= 80 && acks_after == 0; c++) begin
      @(posedge clk); #1;
      if (disp_ack && !cpu_done) begin acks_before++; dd = disp_data; end
      else if (disp_ack) acks_after++;
      if (cpu_ready) begin cpu_done = 1'b1; rd = cpu_rdata; cpu_req = 1'b0; end
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    chk("starve_disp_acks", acks_before, 4);
    chk("starve_cpu_served", {31'h0, cpu_done}, 32'h1);
    chk("starve_cpu_rdata", {24'h0, rd}, 32'h5A);
    chk("starve_disp_data", {8'h0, dd}, 32'h003CA55A);
    chk("starve_disp_resumes", acks_after, 1);
    idle(6);

    // Reset asserted while a read is waiting on the RAM.
    cpu_plane = 2'd1; cpu_addr = 14'h0123; cpu_we = 1'b0; cpu_req = 1'b1;
    idle(2);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("rst_mid_outputs", {8'h0, cpu_rdata, 7'h0, cpu_ready, disp_ack, mem_ce, mem_we}, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_data", {disp_data, mem_wdata}, 32'h0);
    chk("rst_mid_addr", {18'h0, mem_addr}, 32'h0);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (cpu_ready || disp_ack || mem_ce != 3'b000) pulses++;
    end
    chk("rst_mid_no_pulse", pulses, 0);

`ifdef SUB_VRAM_WBUF_EN
    // Posted write followed immediately by a read of the same location.
    run_cpu(2'd2, 14'h3FFF, 1'b1, 8'h5C, ce_or, ce_cnt, rdy, rd);
    chk("wbuf_write_ready", rdy, 1);
    run_cpu(2'd2, 14'h3FFF, 1'b0, 8'h00, ce_or, ce_cnt, rdy, rd);
    chk("wbuf_read_ce_count", ce_cnt, 2);
    chk("wbuf_read_ready", rdy, 6);
    chk("wbuf_read_rdata", {24'h0, rd}, 32'h5C);
    idle(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
